// File: rtl/ibex_mem_arbiter.sv
// N-host arbiter in front of a single-port SRAM with a 1-cycle read latency.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority (host 0 highest).
module ibex_mem_arbiter #(
  parameter int unsigned NumHosts = 2,
  parameter int unsigned MemSize  = 8192,
  parameter logic [31:0] MemStart = 32'h00000000,
  parameter int unsigned HostIdxW = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
  input  logic                     clk_sys,
  input  logic                     rst_sys,
  input  logic [NumHosts-1:0]      host_req_i,
  input  logic [NumHosts-1:0]      host_we_i,
  input  logic [4*NumHosts-1:0]    host_be_i,
  input  logic [32*NumHosts-1:0]   host_addr_i,
  input  logic [32*NumHosts-1:0]   host_wdata_i,
  output logic [NumHosts-1:0]      host_gnt_o,
  output logic [NumHosts-1:0]      host_rvalid_o,
  output logic [NumHosts-1:0]      host_err_o,
  output logic [32*NumHosts-1:0]   host_rdata_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [3:0]               mem_be_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  input  logic                     mem_rvalid_i,
  input  logic [31:0]              mem_rdata_i
);

  localparam logic [31:0] OffMask = 32'(MemSize - 1);

  logic                sel_valid;
  logic [HostIdxW-1:0] sel_idx;
  logic                sel_we;
  logic [3:0]          sel_be;
  logic [31:0]         sel_addr;
  logic [31:0]         sel_wdata;
  logic                in_window;
  logic                mem_access;

  logic                rsp_valid;
  logic                rsp_err;
  logic [HostIdxW-1:0] rsp_host;

`ifdef ARB_ROUND_ROBIN_EN
  logic [HostIdxW-1:0] rr_ptr;
  logic                hi_valid;
  logic [HostIdxW-1:0] hi_idx;
  logic                lo_valid;
  logic [HostIdxW-1:0] lo_idx;

  // Lowest requester at/after the pointer wins, otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_valid = 1'b0;
    lo_idx   = '0;
    for (int i = int'(NumHosts) - 1; i >= 0; i--) begin
      if (host_req_i[i]) begin
        if (HostIdxW'(i) >= rr_ptr) begin
          hi_valid = 1'b1;
          hi_idx   = HostIdxW'(i);
        end
        lo_valid = 1'b1;
        lo_idx   = HostIdxW'(i);
      end
    end
    sel_valid = hi_valid | lo_valid;
    sel_idx   = hi_valid ? hi_idx : lo_idx;
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      rr_ptr <= '0;
    end else if (sel_valid) begin
      rr_ptr <= (sel_idx == HostIdxW'(NumHosts - 1)) ? '0 : sel_idx + HostIdxW'(1);
    end
  end
`else
  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = int'(NumHosts) - 1; i >= 0; i--) begin
      if (host_req_i[i]) begin
        sel_valid = 1'b1;
        sel_idx   = HostIdxW'(i);
      end
    end
  end
`endif

  // Grant decode and request mux; nothing is granted while reset is held.
  always_comb begin
    host_gnt_o = '0;
    sel_we     = 1'b0;
    sel_be     = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    for (int i = 0; i < int'(NumHosts); i++) begin
      if (sel_valid && (sel_idx == HostIdxW'(i))) begin
        host_gnt_o[i] = !rst_sys;
        sel_we        = host_we_i[i];
        sel_be        = host_be_i[4*i +: 4];
        sel_addr      = host_addr_i[32*i +: 32];
        sel_wdata     = host_wdata_i[32*i +: 32];
      end
    end
  end

  assign in_window  = ((sel_addr & ~OffMask) == MemStart);
  assign mem_access = sel_valid & in_window & !rst_sys;

  // Out-of-window accesses never reach the RAM, so they cannot cause a side effect.
  assign mem_req_o   = mem_access;
  assign mem_we_o    = mem_access & sel_we;
  assign mem_be_o    = mem_access ? sel_be : 4'b0000;
  assign mem_addr_o  = mem_access ? (sel_addr & OffMask) : 32'h0;
  assign mem_wdata_o = mem_access ? sel_wdata : 32'h0;

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      rsp_valid <= 1'b0;
      rsp_host  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= sel_valid;
      rsp_host  <= sel_idx;
      rsp_err   <= !in_window;
    end
  end

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    for (int i = 0; i < int'(NumHosts); i++) begin
      if (rsp_host == HostIdxW'(i)) begin
        host_rvalid_o[i] = rsp_valid;
        host_err_o[i]    = rsp_valid & rsp_err;
      end
    end
  end

  assign host_rdata_o = {NumHosts{mem_rdata_i}};

`ifndef SYNTHESIS
  gnt_onehot_a : assert property (@(posedge clk_sys) disable iff (rst_sys)
    $onehot0(host_gnt_o));
  rsp_mem_valid_a : assert property (@(posedge clk_sys) disable iff (rst_sys)
    (rsp_valid && !rsp_err) |-> mem_rvalid_i);
`endif

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Self-checking bench for ibex_mem_arbiter: three hosts, 8 KiB window at 0, behavioural 1-cycle RAM.
module tb_ibex_mem_arbiter;

  localparam int unsigned NH = 3;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrMode = 1'b1;
`else
  localparam bit RrMode = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic rst_sys;
  always #5 clk_sys = ~clk_sys;

  logic [NH-1:0]    req, we;
  logic [4*NH-1:0]  be;
  logic [32*NH-1:0] addr, wdata;
  logic [NH-1:0]    gnt, rvalid, err;
  logic [32*NH-1:0] rdata;
  logic             mem_req, mem_we, mem_rvalid;
  logic [3:0]       mem_be;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;

  ibex_mem_arbiter #(
    .NumHosts(NH),
    .MemSize (8192),
    .MemStart(32'h00000000)
  ) dut (
    .clk_sys      (clk_sys),
    .rst_sys      (rst_sys),
    .host_req_i   (req),
    .host_we_i    (we),
    .host_be_i    (be),
    .host_addr_i  (addr),
    .host_wdata_i (wdata),
    .host_gnt_o   (gnt),
    .host_rvalid_o(rvalid),
    .host_err_o   (err),
    .host_rdata_o (rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata)
  );

  // Behavioural single-port RAM, 1-cycle read latency, preloaded while ram_load is high.
  logic [31:0] ram [0:2047];
  logic        ram_load;
  always @(posedge clk_sys) begin
    mem_rvalid <= mem_req;
    if (ram_load) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 32'(i) * 32'h9E3779B1;
    end else if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[12:2]];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    int          host;
    logic        err;
    logic        chk;
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        sb[$];
  logic [31:0] ref_mem [0:2047];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic set_host(input int h, input logic r, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d);
    req[h] = r;
    we[h] = w;
    be[4*h +: 4] = b;
    addr[32*h +: 32] = a;
    wdata[32*h +: 32] = d;
  endtask

  task automatic idle_all();
    req = '0; we = '0; be = '0; addr = '0; wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Record the expected response for the access host h is presenting now, and update the reference memory.
  task automatic accept(input int h);
    rsp_t        e;
    logic [31:0] a;
    int          w;
    a = addr[32*h +: 32];
    w = int'(a[12:2]);
    e.host = h;
    e.err  = (a[31:13] != 19'd0);
    e.chk  = !e.err && !we[h];
    e.data = ref_mem[w];
    e.due  = cyc + 1;
    if (!e.err && we[h])
      for (int b = 0; b < 4; b++)
        if (be[4*h + b]) ref_mem[w][8*b +: 8] = wdata[32*h + 8*b +: 8];
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every cycle out of reset, rvalid must match the oldest due entry or be zero.
  task automatic monitor();
    rsp_t          e;
    logic [NH-1:0] exp_rv, exp_err;
    forever begin
      @(negedge clk_sys);
      if (!rst_sys) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          exp_rv = '0;
          exp_rv[e.host] = 1'b1;
          exp_err = e.err ? exp_rv : '0;
          n_checks++;
          if (rvalid !== exp_rv || e.due != cyc)
            $display("FAIL rsp_rvalid cyc %0d got %b exp %b (due %0d)", cyc, rvalid, exp_rv, e.due);
          else n_pass++;
          n_checks++;
          if (err !== exp_err) $display("FAIL rsp_err cyc %0d got %b exp %b", cyc, err, exp_err);
          else n_pass++;
          if (e.chk) begin
            n_checks++;
            if (rdata[32*e.host +: 32] !== e.data)
              $display("FAIL rsp_rdata host %0d got %h exp %h", e.host, rdata[32*e.host +: 32], e.data);
            else n_pass++;
          end
        end else begin
          n_checks++;
          if (rvalid !== '0) $display("FAIL rsp_spurious cyc %0d got %b exp 000", cyc, rvalid);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset();
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
    set_host(1, 1'b1, 1'b1, 4'hF, 32'h8, 32'hFFFFFFFF);
    set_host(2, 1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
    repeat (2) tick();
    @(negedge clk_sys);
    n_checks++;
    if (gnt !== '0) $display("FAIL reset_gnt got %b exp 000", gnt); else n_pass++;
    n_checks++;
    if (rvalid !== '0) $display("FAIL reset_rvalid got %b exp 000", rvalid); else n_pass++;
    n_checks++;
    if (err !== '0) $display("FAIL reset_err got %b exp 000", err); else n_pass++;
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'd0)
      $display("FAIL reset_mem got req %b we %b be %b addr %h wdata %h exp all 0",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    else n_pass++;
    tick();
    rst_sys = 1'b0;
    ram_load = 1'b0;
    idle_all();
  endtask

  task automatic test_round_robin();
    int            exp_idx;
    logic [NH-1:0] exp_g;
    for (int h = 0; h < int'(NH); h++) set_host(h, 1'b1, 1'b0, 4'hF, 32'h300 + 32'(4*h), 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_sys);
      exp_idx = RrMode ? (c % 3) : 0;
      exp_g = '0;
      exp_g[exp_idx] = 1'b1;
      n_checks++;
      if (gnt !== exp_g) $display("FAIL rr_gnt cycle %0d got %b exp %b", c, gnt, exp_g); else n_pass++;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300 + 32'(4*exp_idx))
        $display("FAIL rr_mem cycle %0d got req %b addr %h exp 1 %h", c, mem_req, mem_addr,
                 32'h300 + 32'(4*exp_idx));
      else n_pass++;
      accept(exp_idx);
      tick();
    end
    idle_all();
  endtask

  task automatic test_fixed_priority();
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    set_host(1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    @(negedge clk_sys);
    n_checks++;
    if (gnt !== 3'b001 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100)
      $display("FAIL fp_first got gnt %b req %b we %b addr %h exp 001 1 0 00000100", gnt, mem_req, mem_we, mem_addr);
    else n_pass++;
    accept(0);
    tick();
    set_host(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk_sys);
    n_checks++;
    if (gnt !== 3'b010 || mem_req !== 1'b1 || mem_addr !== 32'h200)
      $display("FAIL fp_second got gnt %b req %b addr %h exp 010 1 00000200", gnt, mem_req, mem_addr);
    else n_pass++;
    accept(1);
    tick();
    idle_all();
  endtask

  task automatic test_out_of_window();
    set_host(1, 1'b1, 1'b1, 4'hF, 32'h00002004, 32'h12345678);
    @(negedge clk_sys);
    n_checks++;
    if (gnt !== 3'b010 || mem_req !== 1'b0)
      $display("FAIL oow_write got gnt %b req %b exp 010 0", gnt, mem_req);
    else n_pass++;
    accept(1);
    tick();
    set_host(1, 1'b1, 1'b0, 4'hF, 32'h00000004, 32'h0);
    @(negedge clk_sys);
    n_checks++;
    if (gnt !== 3'b010 || mem_req !== 1'b1 || mem_addr !== 32'h4)
      $display("FAIL oow_readback got gnt %b req %b addr %h exp 010 1 00000004", gnt, mem_req, mem_addr);
    else n_pass++;
    accept(1);
    tick();
    idle_all();
  endtask

  task automatic test_back_to_back();
    set_host(0, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hDEADBEEF);
    @(negedge clk_sys);
    n_checks++;
    if (gnt !== 3'b001 || {mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h10, 32'hDEADBEEF})
      $display("FAIL b2b_write got gnt %b req %b we %b be %b addr %h wdata %h", gnt, mem_req, mem_we,
               mem_be, mem_addr, mem_wdata);
    else n_pass++;
    accept(0);
    tick();
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    @(negedge clk_sys);
    n_checks++;
    if (gnt !== 3'b001 || mem_req !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL b2b_read got gnt %b req %b we %b exp 001 1 0", gnt, mem_req, mem_we);
    else n_pass++;
    accept(0);
    tick();
    idle_all();
  endtask

  task automatic test_idle();
    logic [NH-1:0] exp_g;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_sys);
      n_checks++;
      if (gnt !== '0 || mem_req !== 1'b0 || err !== '0)
        $display("FAIL idle cycle %0d got gnt %b req %b err %b exp 000 0 000", c, gnt, mem_req, err);
      else n_pass++;
      tick();
    end
    for (int h = 0; h < int'(NH); h++) set_host(h, 1'b1, 1'b0, 4'hF, 32'h400 + 32'(4*h), 32'h0);
    @(negedge clk_sys);
    exp_g = RrMode ? 3'b010 : 3'b001;
    n_checks++;
    if (gnt !== exp_g) $display("FAIL idle_ptr_hold got %b exp %b", gnt, exp_g); else n_pass++;
    accept(RrMode ? 1 : 0);
    tick();
    idle_all();
  endtask

  task automatic test_reset_mid();
    set_host(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    @(negedge clk_sys);
    n_checks++;
    if (gnt !== 3'b001) $display("FAIL rstmid_grant got %b exp 001", gnt); else n_pass++;
    tick();
    rst_sys = 1'b1;
    for (int h = 0; h < int'(NH); h++) set_host(h, 1'b1, 1'b0, 4'hF, 32'h500 + 32'(4*h), 32'h0);
    @(negedge clk_sys);
    n_checks++;
    if (gnt !== '0 || rvalid !== '0 || err !== '0 || mem_req !== 1'b0)
      $display("FAIL rstmid_during got gnt %b rvalid %b err %b req %b exp all 0", gnt, rvalid, err, mem_req);
    else n_pass++;
    tick();
    rst_sys = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (gnt !== 3'b001) $display("FAIL rstmid_ptr got %b exp 001", gnt); else n_pass++;
    accept(0);
    tick();
    idle_all();
  endtask

  initial begin
    rst_sys = 1'b1;
    ram_load = 1'b1;
    idle_all();
    for (int i = 0; i < 2048; i++) ref_mem[i] = 32'(i) * 32'h9E3779B1;
    fork
      monitor();
    join_none
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_out_of_window();
    test_back_to_back();
    test_idle();
    test_reset_mid();
    repeat (3) tick();
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_drain got %0d pending exp 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
